// File: rtl/cclu_pkg.sv
// Shared types for the CCLU loop-control initiator.
//   cmd_e   : CCLU command encoding, also used for fetch request ops
//   state_e : issuer FSM states
//   CCLU_DEPTH : number of loop entries held by the CCLU
package cclu_pkg;

   localparam int CCLU_DEPTH = 16;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_LOOP = 2'b01,
      CMD_POP  = 2'b10,
      CMD_CLR  = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      RESP1,
      RESP2,
      DONE
   } state_e;

endpackage

// File: rtl/cclu_issue_stats.sv
// Saturating event counters for the loop issuer.
// Ports:
//   clk, reset      clock / async active-low reset
//   done            one-cycle strobe, a response is being produced
//   issued          the finishing request sent a command to the CCLU
//   redirect        the finishing request redirects fetch
//   error           the finishing request reports an error
//   stat_issued     count of responses for commands sent to the CCLU
//   stat_redirects  count of redirect responses
//   stat_errors     count of error responses
module cclu_issue_stats (
   input  logic        clk,
   input  logic        reset,
   input  logic        done,
   input  logic        issued,
   input  logic        redirect,
   input  logic        error,
   output logic [31:0] stat_issued,
   output logic [31:0] stat_redirects,
   output logic [31:0] stat_errors
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_issued    <= '0;
         stat_redirects <= '0;
         stat_errors    <= '0;
      end else if (done) begin
         if (issued   && stat_issued    != '1) stat_issued    <= stat_issued + 32'd1;
         if (redirect && stat_redirects != '1) stat_redirects <= stat_redirects + 32'd1;
         if (error    && stat_errors    != '1) stat_errors    <= stat_errors + 32'd1;
      end
   end

endmodule

// File: rtl/cclu_loop_issuer.sv
// Initiator side of the CCLU loop-control interface. Accepts one fetch
// request at a time (valid/ready), sends a single-cycle CCLU command, gathers
// the two-phase CCLU response and returns one redirect/error strobe.
// Ports:
//   clk, reset                  clock / async active-low reset
//   req_valid/req_ready         fetch request handshake
//   req_op/addr/target/count    request fields, captured at accept
//   rsp_valid                   one-cycle response strobe
//   rsp_redirect/target/error   response fields, zero when rsp_valid is low
//   cclu_command/addr/target/counter/clr  CCLU drive
//   cclu_valid/error/full/target_out      CCLU response
//   stat_issued/redirects/errors          only with CCLU_ISSUE_STATS_EN
// Optional feature macro: CCLU_ISSUE_STATS_EN adds the event counters.
module cclu_loop_issuer
   import cclu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_target,
   input  logic [CNT_W-1:0]  req_count,
   output logic              rsp_valid,
   output logic              rsp_redirect,
   output logic [ADDR_W-1:0] rsp_target,
   output logic              rsp_error,
   output logic [1:0]        cclu_command,
   output logic [ADDR_W-1:0] cclu_addr,
   output logic [ADDR_W-1:0] cclu_target,
   output logic [CNT_W-1:0]  cclu_counter,
   output logic              cclu_clr,
   input  logic              cclu_valid,
   input  logic              cclu_error,
   input  logic              cclu_full,
   input  logic [ADDR_W-1:0] cclu_target_out
`ifdef CCLU_ISSUE_STATS_EN
   ,
   output logic [31:0]       stat_issued,
   output logic [31:0]       stat_redirects,
   output logic [31:0]       stat_errors
`endif
);

   state_e            state_q, state_d;
   cmd_e              op_in, op_q;
   logic              accept, zero_reject;
   logic              v1_q, e1_q, e2_q;
   logic [ADDR_W-1:0] tgt_q;
   logic              done_err, done_redir;

   // The CCLU itself resolves hit/miss when full, so full is not acted on here.
   logic unused_full;
   assign unused_full = cclu_full;

   assign op_in       = cmd_e'(req_op);
   assign accept      = req_valid && req_ready;
   assign zero_reject = (op_in == CMD_LOOP) && (req_count == '0);

   assign done_err   = e1_q || e2_q;
   assign done_redir = v1_q && !done_err && (op_q != CMD_CLR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (zero_reject)           state_d = DONE;
               else if (op_in != CMD_NOP) state_d = ISSUE;
            end
         end
         ISSUE:   state_d = RESP1;
         RESP1:   state_d = RESP2;
         RESP2:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are all registered, so each one reflects the state just left:
   // the command is visible while in ISSUE, the response strobe in the cycle
   // after DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_redirect <= 1'b0;
         rsp_target   <= '0;
         rsp_error    <= 1'b0;
         cclu_command <= CMD_NOP;
         cclu_addr    <= '0;
         cclu_target  <= '0;
         cclu_counter <= '0;
         cclu_clr     <= 1'b0;
         op_q         <= CMD_NOP;
         v1_q         <= 1'b0;
         e1_q         <= 1'b0;
         e2_q         <= 1'b0;
         tgt_q        <= '0;
      end else begin
         req_ready    <= (state_d == IDLE);
         rsp_valid    <= 1'b0;
         rsp_redirect <= 1'b0;
         rsp_target   <= '0;
         rsp_error    <= 1'b0;
         cclu_command <= CMD_NOP;
         cclu_clr     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept && op_in != CMD_NOP) begin
                  op_q  <= op_in;
                  v1_q  <= 1'b0;
                  e2_q  <= 1'b0;
                  tgt_q <= '0;
                  // A zero-count loop never reaches the CCLU; the error is
                  // preloaded so DONE reports it without special casing.
                  e1_q  <= zero_reject;
                  if (!zero_reject) begin
                     cclu_command <= op_in;
                     cclu_addr    <= req_addr;
                     cclu_target  <= req_target;
                     cclu_counter <= req_count;
                     cclu_clr     <= (op_in == CMD_CLR);
                  end
               end
            end
            RESP1: begin
               v1_q <= cclu_valid;
               e1_q <= cclu_error;
            end
            RESP2: begin
               e2_q  <= cclu_error;
               tgt_q <= cclu_target_out;
            end
            DONE: begin
               rsp_valid    <= 1'b1;
               rsp_error    <= done_err;
               rsp_redirect <= done_redir;
               rsp_target   <= done_redir ? tgt_q : '0;
            end
            default: ;
         endcase
      end
   end

`ifdef CCLU_ISSUE_STATS_EN
   logic issued_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                            issued_q <= 1'b0;
      else if (state_q == IDLE && accept && op_in != CMD_NOP) issued_q <= !zero_reject;
   end

   cclu_issue_stats u_stats (
      .clk            (clk),
      .reset          (reset),
      .done           (state_q == DONE),
      .issued         (issued_q),
      .redirect       (done_redir),
      .error          (done_err),
      .stat_issued    (stat_issued),
      .stat_redirects (stat_redirects),
      .stat_errors    (stat_errors)
   );
`endif

endmodule

// File: tb/tb_cclu_loop_issuer.sv
// Bench for cclu_loop_issuer: behavioural CCLU table model plus a response
// scoreboard. Expected responses are predicted from the model table when a
// request is about to be accepted and checked when rsp_valid fires.
module tb_cclu_loop_issuer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_addr = '0, req_target = '0, req_count = '0;
   logic        rsp_valid, rsp_redirect, rsp_error;
   logic [31:0] rsp_target;
   logic [1:0]  cclu_command;
   logic [31:0] cclu_addr, cclu_target, cclu_counter;
   logic        cclu_clr;
   logic        cclu_valid = 1'b0, cclu_error = 1'b0, cclu_full;
   logic [31:0] cclu_target_out = '0;
`ifdef CCLU_ISSUE_STATS_EN
   logic [31:0] stat_issued, stat_redirects, stat_errors;
`endif

   always #5 clk = ~clk;

   cclu_loop_issuer #(.ADDR_W(32), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_target(req_target), .req_count(req_count),
      .rsp_valid(rsp_valid), .rsp_redirect(rsp_redirect),
      .rsp_target(rsp_target), .rsp_error(rsp_error),
      .cclu_command(cclu_command), .cclu_addr(cclu_addr),
      .cclu_target(cclu_target), .cclu_counter(cclu_counter),
      .cclu_clr(cclu_clr), .cclu_valid(cclu_valid), .cclu_error(cclu_error),
      .cclu_full(cclu_full), .cclu_target_out(cclu_target_out)
`ifdef CCLU_ISSUE_STATS_EN
      , .stat_issued(stat_issued), .stat_redirects(stat_redirects),
      .stat_errors(stat_errors)
`endif
   );

   int n_tests = 0, n_fail = 0;
   int cyc = 0, ncmd = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- CCLU model ----------------
   logic [31:0] t_addr [16];
   logic [31:0] t_tgt  [16];
   int          n_ent = 0;
   logic        m_v, m_e, m_e2, p_e2 = 1'b0;
   logic [31:0] m_t, p_tgt = '0;
   int          m_h;

   assign cclu_full = (n_ent == cclu_pkg::CCLU_DEPTH);

   function automatic int find(input logic [31:0] a);
      for (int i = 0; i < n_ent; i++) if (t_addr[i] == a) return i;
      return -1;
   endfunction

   // valid/error one cycle after the command, target and full-miss error two.
   always @(posedge clk) begin
      m_v = 1'b0; m_e = 1'b0; m_e2 = 1'b0; m_t = '0;
      if (cclu_clr) n_ent = 0;
      else case (cclu_command)
         2'b01: begin
            m_h = find(cclu_addr);
            if (m_h >= 0) begin m_v = 1'b1; m_t = t_tgt[m_h]; end
            else if (n_ent < 16) begin
               t_addr[n_ent] = cclu_addr; t_tgt[n_ent] = cclu_target; n_ent++;
               m_v = 1'b1; m_t = cclu_target;
            end else begin m_v = 1'b1; m_e2 = 1'b1; end
         end
         2'b10: if (n_ent == 0) m_e = 1'b1; else n_ent--;
         default: ;
      endcase
      cclu_valid      <= m_v;
      cclu_error      <= m_e | p_e2;
      p_e2            <= m_e2;
      p_tgt           <= m_t;
      cclu_target_out <= p_tgt;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        err;
      logic        redir;
      logic [31:0] tgt;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (cclu_command != 2'b00) ncmd++;
         if (cclu_clr) chk("clr_cmd", cclu_command, 2'b11);
         if (rsp_valid) begin
            if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
               e = sbq.pop_front();
               chk("rsp_error", rsp_error, e.err);
               chk("rsp_redirect", rsp_redirect, e.redir);
               chk("rsp_target", rsp_target, e.tgt);
               chk("rsp_latency_cyc", cyc, e.cyc);
            end
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] t,
                       input logic [31:0] c, output int waits);
      exp_t e;
      int   lat, h;
      waits = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = a; req_target = t; req_count = c;
      while (!req_ready && waits < 50) begin @(negedge clk); waits++; end
      if (!req_ready) begin
         chk("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      e.err = 1'b0; e.redir = 1'b0; e.tgt = '0; lat = 4;
      case (op)
         2'b01: begin
            h = find(a);
            if (c == 0) begin e.err = 1'b1; lat = 1; end
            else if (h >= 0) begin e.redir = 1'b1; e.tgt = t_tgt[h]; end
            else if (n_ent < 16) begin e.redir = 1'b1; e.tgt = t; end
            else e.err = 1'b1;
         end
         2'b10: e.err = (n_ent == 0);
         default: ;
      endcase
      e.cyc = cyc + 1 + lat;
      if (op != 2'b00) sbq.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sbq.size() != 0 && k < 40) begin @(negedge clk); k++; end
      if (sbq.size() != 0) begin
         chk("rsp_timeout", sbq.size(), 0);
         sbq.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int   w, w2, c0;
      exp_t dropped;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_target", rsp_target, 0);
      chk("rst_cclu_command", cclu_command, 0);
      chk("rst_cclu_clr", cclu_clr, 0);
      chk("rst_cclu_addr", cclu_addr, 0);
      chk("rst_cclu_counter", cclu_counter, 0);
      reset = 1'b1;

      // Basic loop: command for one cycle, redirect after 4 cycles
      c0 = ncmd;
      send(2'b01, 32'h100, 32'h80, 32'd3, w);
      @(negedge clk);
      chk("loop_cmd", cclu_command, 2'b01);
      chk("loop_addr", cclu_addr, 32'h100);
      chk("loop_tgt", cclu_target, 32'h80);
      chk("loop_cnt", cclu_counter, 32'd3);
      @(negedge clk);
      chk("loop_cmd_1cyc", cclu_command, 2'b00);
      wait_idle();
      chk("loop_ncmd", ncmd - c0, 1);

      // Zero-count reject: never reaches the CCLU
      c0 = ncmd;
      send(2'b01, 32'h140, 32'h90, 32'd0, w);
      wait_idle();
      chk("zero_ncmd", ncmd - c0, 0);

      // NOP is swallowed without a response
      c0 = ncmd;
      send(2'b00, 32'h150, 32'h10, 32'd1, w);
      repeat (5) @(negedge clk);
      chk("nop_ready", req_ready, 1);
      chk("nop_ncmd", ncmd - c0, 0);

      // Fill the table, then full-miss and full-hit
      for (int i = 0; i < 15; i++) begin
         send(2'b01, 32'h1000 + i * 4, 32'h2000 + i * 4, 32'd2, w);
         wait_idle();
      end
      send(2'b01, 32'h200, 32'h60, 32'd5, w);
      wait_idle();
      send(2'b01, 32'h100, 32'h70, 32'd4, w);
      wait_idle();
      send(2'b10, 32'h0, 32'h0, 32'd0, w);
      wait_idle();

      // Clear, then the old address misses and takes the new target
      send(2'b11, 32'h0, 32'h0, 32'd0, w);
      @(negedge clk);
      chk("clr_pulse", cclu_clr, 1);
      chk("clr_command", cclu_command, 2'b11);
      @(negedge clk);
      chk("clr_pulse_1cyc", cclu_clr, 0);
      wait_idle();
      send(2'b01, 32'h100, 32'h40, 32'd2, w);
      wait_idle();
      send(2'b10, 32'h0, 32'h0, 32'd0, w);
      wait_idle();
      send(2'b10, 32'h0, 32'h0, 32'd0, w);  // pop on empty CCLU -> error
      wait_idle();

      // Back-to-back: second request waits out the busy window
      c0 = ncmd;
      send(2'b01, 32'h400, 32'h44, 32'd7, w);
      send(2'b01, 32'h404, 32'h48, 32'd7, w2);
      chk("busy_waits", w2, 4);
      wait_idle();
      chk("busy_ncmd", ncmd - c0, 2);

      // Reset in the middle of RESP1 aborts silently
      send(2'b01, 32'h300, 32'h30, 32'd1, w);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_req_ready", req_ready, 1);
      chk("abort_cclu_command", cclu_command, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      dropped = sbq.pop_back();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", rsp_valid, 0);
      end
      chk("abort_sbq_empty", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
